// File: rtl/pc_unit_if.sv
// Program-counter unit bus bundle.
// Groups the control-side request signals and the PC/trace results of pc_unit.
//   master : control FSM / debug side (drives i_*, samples o_*)
//   slave  : pc_unit itself (samples i_*, drives o_*)
// Signals (named from pc_unit's point of view):
//   i_pc_en, i_pc_src[1:0], i_br_taken, i_br_imm[15:0], i_j_index[25:0],
//   i_reg_target[ADDR_W-1:0], i_exc_req, i_eret, i_hist_idx[HW-1:0]
//   o_pc_out, o_pc_plus4, o_epc, o_misalign, o_hist_pc, o_hist_count[HW:0]
interface pc_unit_if #(
  parameter int ADDR_W     = 32,
  parameter int HIST_DEPTH = 8
);
  localparam int HW = $clog2(HIST_DEPTH);

  logic              i_pc_en;
  logic [1:0]        i_pc_src;
  logic              i_br_taken;
  logic [15:0]       i_br_imm;
  logic [25:0]       i_j_index;
  logic [ADDR_W-1:0] i_reg_target;
  logic              i_exc_req;
  logic              i_eret;
  logic [HW-1:0]     i_hist_idx;

  logic [ADDR_W-1:0] o_pc_out;
  logic [ADDR_W-1:0] o_pc_plus4;
  logic [ADDR_W-1:0] o_epc;
  logic              o_misalign;
  logic [ADDR_W-1:0] o_hist_pc;
  logic [HW:0]       o_hist_count;

  modport master (
    output i_pc_en, i_pc_src, i_br_taken, i_br_imm, i_j_index, i_reg_target,
           i_exc_req, i_eret, i_hist_idx,
    input  o_pc_out, o_pc_plus4, o_epc, o_misalign, o_hist_pc, o_hist_count
  );

  modport slave (
    input  i_pc_en, i_pc_src, i_br_taken, i_br_imm, i_j_index, i_reg_target,
           i_exc_req, i_eret, i_hist_idx,
    output o_pc_out, o_pc_plus4, o_epc, o_misalign, o_hist_pc, o_hist_count
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit for the multi-cycle MIPS datapath.
// Holds the PC, forms the next PC for sequential / branch / jump / jr flows,
// handles exception entry (EPC capture) and eret, rejects misaligned jr
// targets with a one-cycle pulse, and keeps a ring of recently left PCs.
// Ports:
//   i_clk  : rising-edge clock
//   i_rst  : synchronous reset, active high
//   bus    : pc_unit_if.slave (requests in, PC / EPC / trace out)
module pc_unit #(
  parameter int          ADDR_W       = 32,
  parameter int unsigned RESET_VECTOR = 240,
  parameter int unsigned EXC_VECTOR   = 384,
  parameter int          HIST_DEPTH   = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  pc_unit_if.slave   bus
);
  localparam int HW = $clog2(HIST_DEPTH);
  localparam logic [ADDR_W-1:0] RV = ADDR_W'(RESET_VECTOR);
  localparam logic [ADDR_W-1:0] EV = ADDR_W'(EXC_VECTOR);
  localparam logic [HW:0]       FULL = (HW+1)'(HIST_DEPTH);

  logic [ADDR_W-1:0] r_pc, r_epc;
  logic              r_misalign;
  logic [ADDR_W-1:0] r_ring [HIST_DEPTH];
  logic [HW-1:0]     r_wr_ptr;
  logic [HW:0]       r_count;

  logic [ADDR_W-1:0] w_pc_plus4, w_br_off, w_jmp, w_target;
  logic [HW-1:0]     w_rd_ptr;
  logic              w_misal, w_push;

  assign w_pc_plus4 = r_pc + ADDR_W'(4);
  // Word offset, sign-extended and scaled to bytes.
  assign w_br_off   = {{(ADDR_W-18){bus.i_br_imm[15]}}, bus.i_br_imm, 2'b00};

  // With a 28-bit PC the jump index covers the whole address space.
  generate
    if (ADDR_W == 28) begin : g_jmp28
      assign w_jmp = {bus.i_j_index, 2'b00};
    end else begin : g_jmpn
      assign w_jmp = {w_pc_plus4[ADDR_W-1:28], bus.i_j_index, 2'b00};
    end
  endgenerate

  always_comb begin
    w_target = w_pc_plus4;
    case (bus.i_pc_src)
      2'd1:    w_target = bus.i_br_taken ? (w_pc_plus4 + w_br_off) : w_pc_plus4;
      2'd2:    w_target = w_jmp;
      2'd3:    w_target = bus.i_reg_target;
      default: w_target = w_pc_plus4;
    endcase
  end

  assign w_misal = (w_target[1:0] != 2'b00);
  // Exception and eret always leave the current PC; a plain update only when
  // its target is accepted.
  assign w_push  = bus.i_exc_req | bus.i_eret | (bus.i_pc_en & ~w_misal);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc       <= RV;
      r_epc      <= '0;
      r_misalign <= 1'b0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_misalign <= 1'b0;
      if (bus.i_exc_req) begin
        r_epc <= r_pc;
        r_pc  <= EV;
      end else if (bus.i_eret) begin
        r_pc  <= r_epc + ADDR_W'(4);
      end else if (bus.i_pc_en) begin
        if (w_misal) begin
          r_misalign <= 1'b1;
          r_epc      <= w_target;
        end else begin
          r_pc       <= w_target;
        end
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + HW'(1);
        if (r_count != FULL) r_count <= r_count + (HW+1)'(1);
      end
    end
  end

  // Trace storage is never cleared; entries past hist_count are stale.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) r_ring[r_wr_ptr] <= r_pc;
  end

  // Power-of-two depth makes the pointer arithmetic wrap for free.
  assign w_rd_ptr = r_wr_ptr - HW'(1) - bus.i_hist_idx;

  assign bus.o_pc_out     = r_pc;
  assign bus.o_pc_plus4   = w_pc_plus4;
  assign bus.o_epc        = r_epc;
  assign bus.o_misalign   = r_misalign;
  assign bus.o_hist_pc    = r_ring[w_rd_ptr];
  assign bus.o_hist_count = r_count;
endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
  localparam int DEPTH = 8;
  localparam logic [31:0] RV = 32'hF0;
  localparam logic [31:0] EV = 32'h180;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_unit_if #(.ADDR_W(32), .HIST_DEPTH(DEPTH)) bus ();

  pc_unit #(.ADDR_W(32), .RESET_VECTOR(240), .EXC_VECTOR(384), .HIST_DEPTH(DEPTH))
    dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: architectural PC/EPC plus a newest-first list of left PCs.
  logic [31:0] m_pc, m_epc;
  logic        m_mis;
  logic [31:0] mh[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic hchk(input string tag, input int idx, input logic [31:0] exp);
    bus.i_hist_idx = 3'(idx);
    #1;
    chk(tag, bus.o_hist_pc, exp);
  endtask

  task automatic push_hist(input logic [31:0] v);
    mh.push_front(v);
    if (mh.size() > DEPTH) void'(mh.pop_back());
  endtask

  task automatic step(input logic rs, exc, er, en, input logic [1:0] src,
                      input logic bt, input logic [15:0] imm,
                      input logic [25:0] ji, input logic [31:0] rt);
    logic [31:0] pc4, tgt;
    int idx;
    rst = rs; bus.i_exc_req = exc; bus.i_eret = er; bus.i_pc_en = en;
    bus.i_pc_src = src; bus.i_br_taken = bt; bus.i_br_imm = imm;
    bus.i_j_index = ji; bus.i_reg_target = rt;
    pc4 = m_pc + 32'd4;
    case (src)
      2'd0: tgt = pc4;
      2'd1: tgt = bt ? pc4 + 32'($signed(imm)) * 32'd4 : pc4;
      2'd2: tgt = {pc4[31:28], ji, 2'b00};
      default: tgt = rt;
    endcase
    if (rs) begin
      m_pc = RV; m_epc = 0; m_mis = 0; mh.delete();
    end else begin
      m_mis = 0;
      if (exc) begin
        push_hist(m_pc); m_epc = m_pc; m_pc = EV;
      end else if (er) begin
        push_hist(m_pc); m_pc = m_epc + 32'd4;
      end else if (en) begin
        if (tgt[1:0] != 2'b00) begin m_mis = 1; m_epc = tgt; end
        else begin push_hist(m_pc); m_pc = tgt; end
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.i_exc_req = 0; bus.i_eret = 0; bus.i_pc_en = 0;
    chk("pc_out", bus.o_pc_out, m_pc);
    chk("pc_plus4", bus.o_pc_plus4, m_pc + 32'd4);
    chk("epc", bus.o_epc, m_epc);
    chk("misalign", 32'(bus.o_misalign), 32'(m_mis));
    chk("hist_count", 32'(bus.o_hist_count), 32'(mh.size()));
    if (mh.size() > 0) begin
      idx = $urandom_range(0, mh.size() - 1);
      hchk("hist_pc_rand", idx, mh[idx]);
    end
  endtask

  task automatic seq();              step(0,0,0,1,2'd0,0,16'h0,26'h0,32'h0); endtask
  task automatic setpc(input logic [31:0] v); step(0,0,0,1,2'd3,0,16'h0,26'h0,v); endtask
  task automatic hold();             step(0,0,0,0,2'd0,0,16'h0,26'h0,32'h0); endtask
  task automatic reset();            step(1,0,0,0,2'd0,0,16'h0,26'h0,32'h0); endtask

  initial begin
    m_pc = 'x; m_epc = 'x; m_mis = 0;
    bus.i_pc_en = 0; bus.i_pc_src = 0; bus.i_br_taken = 0; bus.i_br_imm = 0;
    bus.i_j_index = 0; bus.i_reg_target = 0; bus.i_exc_req = 0; bus.i_eret = 0;
    bus.i_hist_idx = 0;
    #2;

    // 1: reset state, sequential flow, trace readback
    reset();
    chk("t1_rst_pc", bus.o_pc_out, 32'hF0);
    chk("t1_rst_cnt", 32'(bus.o_hist_count), 32'd0);
    chk("t1_rst_epc", bus.o_epc, 32'd0);
    seq(); chk("t1_seq1", bus.o_pc_out, 32'hF4);
    seq(); chk("t1_seq2", bus.o_pc_out, 32'hF8);
    seq(); chk("t1_seq3", bus.o_pc_out, 32'hFC);
    hchk("t1_hist0", 0, 32'hF8);
    hchk("t1_hist2", 2, 32'hF0);
    hold(); chk("t1_hold", bus.o_pc_out, 32'hFC);
    chk("t1_hold_cnt", 32'(bus.o_hist_count), 32'd3);

    // 2: branch taken backwards / not taken
    setpc(32'h100);
    step(0,0,0,1,2'd1,1,16'hFFFE,26'h0,32'h0); chk("t2_br_taken", bus.o_pc_out, 32'hFC);
    setpc(32'h100);
    step(0,0,0,1,2'd1,0,16'hFFFE,26'h0,32'h0); chk("t2_br_not", bus.o_pc_out, 32'h104);

    // 3: jump keeps upper nibble; misaligned jr is rejected
    setpc(32'h1000_0010);
    step(0,0,0,1,2'd2,0,16'h0,26'h40,32'h0); chk("t3_jump", bus.o_pc_out, 32'h1000_0100);
    step(0,0,0,1,2'd3,0,16'h0,26'h0,32'h203);
    chk("t3_mis_pc", bus.o_pc_out, 32'h1000_0100);
    chk("t3_mis_flag", 32'(bus.o_misalign), 32'd1);
    chk("t3_mis_epc", bus.o_epc, 32'h203);
    hold(); chk("t3_mis_clear", 32'(bus.o_misalign), 32'd0);

    // 4: exception beats eret and pc_en, then eret returns to epc+4
    setpc(32'h200);
    step(0,1,1,1,2'd0,0,16'h0,26'h0,32'h0);
    chk("t4_exc_pc", bus.o_pc_out, 32'h180);
    chk("t4_exc_epc", bus.o_epc, 32'h200);
    step(0,0,1,0,2'd0,0,16'h0,26'h0,32'h0);
    chk("t4_eret_pc", bus.o_pc_out, 32'h204);
    chk("t4_eret_epc", bus.o_epc, 32'h200);

    // 5: ring wrap after 10 commits
    reset();
    for (int i = 0; i < 10; i++) seq();
    chk("t5_cnt_sat", 32'(bus.o_hist_count), 32'd8);
    hchk("t5_hist7", 7, 32'hF8);
    hchk("t5_hist0", 0, 32'h114);

    // 6: PC wrap, reset beats exception
    setpc(32'hFFFF_FFFC);
    seq(); chk("t6_wrap", bus.o_pc_out, 32'h0);
    step(1,1,0,1,2'd0,0,16'h0,26'h0,32'h0);
    chk("t6_rst_pc", bus.o_pc_out, 32'hF0);
    chk("t6_rst_epc", bus.o_epc, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rt;
      int r;
      r  = $urandom_range(0, 99);
      rt = $urandom;
      if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
      step(r < 2, (r >= 2 && r < 8), (r >= 6 && r < 12), $urandom_range(0, 3) != 0,
           2'($urandom), 1'($urandom), 16'($urandom), 26'($urandom), rt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
